// File: rtl/reg_readback_tx.sv
// Turns a register read result into a framed byte stream for uart_tx:
// header, address, value bytes (MSB first), XOR checksum.
module reg_readback_tx #(
    parameter int WORD_WIDTH = 8,
    parameter int VALUE_WORDS = 4,
    parameter logic [WORD_WIDTH-1:0] RESP_HEADER = 8'h55,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            i_reset,
    input  logic                            i_r_valid,
    input  logic [WORD_WIDTH-1:0]           i_r_addr,
    input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_r_data,
    output logic                            o_ready,
    output logic [WORD_WIDTH-1:0]           o_data,
    output logic                            o_dv,
    input  logic                            i_busy,
    output logic                            o_overflow
);

    // state | meaning
    // IDLE  | holding register free, o_ready high
    // SEND  | present current byte, strobe o_dv next cycle
    // ACK   | wait for uart busy to rise, bounded by ACK_TIMEOUT
    // DRAIN | wait for uart busy to fall, then advance byte index

    localparam int NUM_BYTES = VALUE_WORDS + 3;
    localparam int IDX_W     = $clog2(NUM_BYTES);
    localparam int VALUE_W   = WORD_WIDTH * VALUE_WORDS;
    localparam int TMR_W     = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state, next_state;
    logic [WORD_WIDTH-1:0] hold_addr, next_addr;
    logic [VALUE_W-1:0]    hold_data, next_data;
    logic [WORD_WIDTH-1:0] hold_csum, next_csum;
    logic [IDX_W-1:0]      idx, next_idx;
    logic [TMR_W-1:0]      tmr, next_tmr;
    logic [WORD_WIDTH-1:0] next_o_data;
    logic                  next_o_dv;
    logic                  next_overflow;
    logic [WORD_WIDTH-1:0] csum_in;
    logic [WORD_WIDTH-1:0] cur_byte;

    assign o_ready = (state == IDLE);

    // Checksum is precomputed from the incoming result at latch time.
    always_comb begin
        csum_in = i_r_addr;
        for (int k = 0; k < VALUE_WORDS; k++) begin
            csum_in = csum_in ^ i_r_data[k*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    always_comb begin
        cur_byte = '0;
        if (idx == '0) begin
            cur_byte = RESP_HEADER;
        end else if (idx == IDX_W'(1)) begin
            cur_byte = hold_addr;
        end else if (idx == IDX_W'(NUM_BYTES - 1)) begin
            cur_byte = hold_csum;
        end else begin
            for (int k = 0; k < VALUE_WORDS; k++) begin
                if (int'(idx) == k + 2) begin
                    cur_byte = hold_data[(VALUE_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    always_comb begin
        next_state    = state;
        next_addr     = hold_addr;
        next_data     = hold_data;
        next_csum     = hold_csum;
        next_idx      = idx;
        next_tmr      = tmr;
        next_o_data   = o_data;
        next_o_dv     = 1'b0;
        next_overflow = i_r_valid && (state != IDLE);

        unique case (state)
            IDLE: begin
                next_idx = '0;
                if (i_r_valid) begin
                    next_addr  = i_r_addr;
                    next_data  = i_r_data;
                    next_csum  = csum_in;
                    next_state = SEND;
                end
            end
            SEND: begin
                next_o_dv   = 1'b1;
                next_o_data = cur_byte;
                next_tmr    = TMR_W'(ACK_TIMEOUT - 1);
                next_state  = ACK;
            end
            ACK: begin
                if (i_busy || (tmr == '0)) begin
                    next_state = DRAIN;
                end else begin
                    next_tmr = tmr - 1'b1;
                end
            end
            DRAIN: begin
                if (!i_busy) begin
                    if (idx == IDX_W'(NUM_BYTES - 1)) begin
                        next_idx   = '0;
                        next_state = IDLE;
                    end else begin
                        next_idx   = idx + 1'b1;
                        next_state = SEND;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= IDLE;
            hold_addr  <= '0;
            hold_data  <= '0;
            hold_csum  <= '0;
            idx        <= '0;
            tmr        <= '0;
            o_data     <= '0;
            o_dv       <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state      <= next_state;
            hold_addr  <= next_addr;
            hold_data  <= next_data;
            hold_csum  <= next_csum;
            idx        <= next_idx;
            tmr        <= next_tmr;
            o_data     <= next_o_data;
            o_dv       <= next_o_dv;
            o_overflow <= next_overflow;
        end
    end

endmodule

// File: tb/tb_reg_readback_tx.sv
// Scoreboard bench for reg_readback_tx: expected frame bytes are queued when a
// read is issued and popped as o_dv strobes appear.
module tb_reg_readback_tx;

    logic        clk;
    logic        i_reset;
    logic        i_r_valid;
    logic [7:0]  i_r_addr;
    logic [31:0] i_r_data;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_dv;
    logic        i_busy;
    logic        o_overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dv_count = 0;
    int ovf_count = 0;
    int busy_cnt = 0;
    bit busy_en = 1'b1;
    logic [7:0] exp_q[$];

    reg_readback_tx dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_r_valid  (i_r_valid),
        .i_r_addr   (i_r_addr),
        .i_r_data   (i_r_data),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_dv       (o_dv),
        .i_busy     (i_busy),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Simple uart_tx stand-in: busy rises the cycle after a strobe, lasts 4 cycles.
    always @(posedge clk) begin
        if (o_dv && busy_en) busy_cnt <= 4;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign i_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (o_overflow) ovf_count = ovf_count + 1;
        if (o_dv) begin
            dv_count = dv_count + 1;
            checks = checks + 1;
            if (i_busy) begin
                errors = errors + 1;
                $display("FAIL dv_while_busy: o_dv=1 with busy=1 at cycle %0d", cyc);
            end
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_byte: got %02h, expected no byte", o_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors = errors + 1;
                    $display("FAIL frame_byte: got %02h, expected %02h", o_data, e);
                end
            end
        end
    end

    function automatic void push_frame(input logic [7:0] a, input logic [31:0] d);
        logic [7:0] cs;
        cs = a;
        exp_q.push_back(8'h55);
        exp_q.push_back(a);
        for (int k = 3; k >= 0; k--) begin
            exp_q.push_back(d[k*8 +: 8]);
            cs = cs ^ d[k*8 +: 8];
        end
        exp_q.push_back(cs);
    endfunction

    // Drives a one-cycle read pulse starting just after the next rising edge.
    task automatic issue_read(input logic [7:0] a, input logic [31:0] d, input bit expect_accept);
        @(posedge clk); #1;
        i_r_valid = 1'b1;
        i_r_addr  = a;
        i_r_data  = d;
        if (expect_accept) push_frame(a, d);
        @(posedge clk); #1;
        i_r_valid = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && o_ready && !i_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_r_valid = 1'b0;
        i_r_addr = '0;
        i_r_data = '0;
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (o_ready !== 1'b1 || o_dv !== 1'b0 || o_data !== 8'h00 || o_overflow !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_state: ready=%b dv=%b data=%02h ovf=%b, expected 1 0 00 0",
                     o_ready, o_dv, o_data, o_overflow);
        end
    endtask

    task automatic test_basic;
        bit to;
        busy_en = 1'b1;
        dv_count = 0;
        ovf_count = 0;
        @(posedge clk); #1;
        i_r_valid = 1'b1;
        i_r_addr = 8'hBB;
        i_r_data = 32'h12345678;
        push_frame(8'hBB, 32'h12345678);
        @(posedge clk); #1;
        i_r_valid = 1'b0;
        checks = checks + 1;
        if (o_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL ready_falls: o_ready=%b, expected 0", o_ready);
        end
        @(negedge clk);
        checks = checks + 1;
        if (o_dv !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL latency_early: o_dv=%b one cycle after accept, expected 0", o_dv);
        end
        @(negedge clk);
        checks = checks + 1;
        if (o_dv !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL latency: o_dv=%b two cycles after accept, expected 1", o_dv);
        end
        wait_done(to);
        checks = checks + 1;
        if (to || dv_count != 7 || ovf_count != 0) begin
            errors = errors + 1;
            $display("FAIL basic_frame: timeout=%0d dv=%0d ovf=%0d, expected 0 7 0", to, dv_count, ovf_count);
        end
    endtask

    task automatic test_overflow;
        bit to;
        dv_count = 0;
        ovf_count = 0;
        issue_read(8'hBB, 32'h12345678, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        checks = checks + 1;
        if (o_ready !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL ovf_ready: o_ready=%b mid-frame, expected 0", o_ready);
        end
        issue_read(8'h01, 32'hCAFEF00D, 1'b0);
        wait_done(to);
        repeat (10) @(negedge clk);
        checks = checks + 1;
        if (to || ovf_count != 1 || dv_count != 7) begin
            errors = errors + 1;
            $display("FAIL overflow: timeout=%0d ovf=%0d dv=%0d, expected 0 1 7", to, ovf_count, dv_count);
        end
    endtask

    task automatic test_timeout;
        bit to;
        bit found;
        int t1, t2;
        busy_en = 1'b0;
        dv_count = 0;
        t1 = 0;
        t2 = 0;
        issue_read(8'h5A, 32'hA5A50F0F, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (o_dv) begin found = 1'b1; t1 = cyc; break; end
            @(negedge clk);
        end
        if (found) begin
            found = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (o_dv) begin found = 1'b1; t2 = cyc; break; end
            end
        end
        checks = checks + 1;
        if (!found || (t2 - t1) != 6) begin
            errors = errors + 1;
            $display("FAIL timeout_gap: found=%0d gap=%0d cycles, expected 1 6", found, t2 - t1);
        end
        wait_done(to);
        checks = checks + 1;
        if (to || dv_count != 7 || o_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL timeout_frame: timeout=%0d dv=%0d ready=%b, expected 0 7 1", to, dv_count, o_ready);
        end
        busy_en = 1'b1;
    endtask

    task automatic test_reset_midframe;
        bit to;
        bit found;
        dv_count = 0;
        issue_read(8'h77, 32'hDEADBEEF, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dv_count == 3) begin found = 1'b1; break; end
        end
        checks = checks + 1;
        if (!found) begin
            errors = errors + 1;
            $display("FAIL third_byte: dv=%0d, expected 3", dv_count);
        end
        @(posedge clk); #1 i_reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 i_reset = 1'b0;
        checks = checks + 1;
        if (o_ready !== 1'b1 || o_dv !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_mid: ready=%b dv=%b, expected 1 0", o_ready, o_dv);
        end
        dv_count = 0;
        repeat (30) @(negedge clk);
        checks = checks + 1;
        if (dv_count != 0) begin
            errors = errors + 1;
            $display("FAIL abandoned_frame: dv=%0d after reset, expected 0", dv_count);
        end
        issue_read(8'h00, 32'h00000000, 1'b1);
        wait_done(to);
        checks = checks + 1;
        if (to || dv_count != 7) begin
            errors = errors + 1;
            $display("FAIL zero_frame: timeout=%0d dv=%0d, expected 0 7", to, dv_count);
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        bit found;
        dv_count = 0;
        ovf_count = 0;
        issue_read(8'h3C, 32'h0BADF00D, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (o_ready) begin found = 1'b1; break; end
        end
        checks = checks + 1;
        if (!found) begin
            errors = errors + 1;
            $display("FAIL b2b_ready: o_ready never returned, expected 1");
        end
        i_r_valid = 1'b1;
        i_r_addr = 8'hC3;
        i_r_data = 32'hF00DFACE;
        push_frame(8'hC3, 32'hF00DFACE);
        @(posedge clk); #1;
        i_r_valid = 1'b0;
        wait_done(to);
        checks = checks + 1;
        if (to || dv_count != 14 || ovf_count != 0) begin
            errors = errors + 1;
            $display("FAIL back_to_back: timeout=%0d dv=%0d ovf=%0d, expected 0 14 0", to, dv_count, ovf_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        repeat (5) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL leftover_bytes: %0d queued, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
